// File: rtl/ppc_accum.sv
`default_nettype none
// ============================================================================
// Module   : ppc_accum
// Purpose  : Accumulates 4-bit approximate partial-product counts into
//            saturating bursts and presents each burst result for handoff.
// Revision : 1.0
// ============================================================================
module ppc_accum #(
  parameter int ACC_W     = 16,
  parameter int MAX_BEATS = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_ans,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_sat
);

  localparam logic [8:0]       c_MAX_BEATS = 9'(MAX_BEATS);
  localparam logic [ACC_W-1:0] c_ACC_MAX   = {ACC_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_sat;

  logic             w_accept;
  logic             w_handoff;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_ovf;
  logic [ACC_W-1:0] w_acc_next;
  logic [8:0]       w_cnt_inc;
  logic             w_close;
  logic             w_in_ready;
  logic             w_out_valid;

  // Accept/handoff decode from the state register only, never from outputs.
  assign w_accept  = in_valid && (r_state != S_HOLD);
  assign w_handoff = out_ready && (r_state == S_HOLD);

  assign w_sum_ext  = {1'b0, r_acc} + {{(ACC_W-3){1'b0}}, in_ans};
  assign w_ovf      = w_sum_ext[ACC_W];
  assign w_acc_next = w_ovf ? c_ACC_MAX : w_sum_ext[ACC_W-1:0];
  assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
  assign w_close    = in_last || (w_cnt_inc == c_MAX_BEATS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b1;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          w_state_next = w_close ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
        if (w_handoff) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath freezes in HOLD so the presented result stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_handoff) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_inc[7:0];
      if (w_ovf) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_sum   = r_acc;
  assign out_count = r_cnt;
  assign out_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_ppc_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppc_accum
// Purpose  : Directed self-checking bench for ppc_accum in four configurations.
// Revision : 1.0
// ============================================================================
module tb_ppc_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // a: defaults, b: MAX_BEATS=4, c: ACC_W=6, d: MAX_BEATS=1
  logic        a_iv = 1'b0, a_last = 1'b0, a_ordy = 1'b0;
  logic [3:0]  a_ans = 4'd0;
  logic        a_irdy, a_ov, a_sat;
  logic [15:0] a_sum;
  logic [7:0]  a_cnt;

  logic        b_iv = 1'b0, b_last = 1'b0, b_ordy = 1'b0;
  logic [3:0]  b_ans = 4'd0;
  logic        b_irdy, b_ov, b_sat;
  logic [15:0] b_sum;
  logic [7:0]  b_cnt;

  logic        c_iv = 1'b0, c_last = 1'b0, c_ordy = 1'b0;
  logic [3:0]  c_ans = 4'd0;
  logic        c_irdy, c_ov, c_sat;
  logic [5:0]  c_sum;
  logic [7:0]  c_cnt;

  logic        d_iv = 1'b0, d_last = 1'b0, d_ordy = 1'b0;
  logic [3:0]  d_ans = 4'd0;
  logic        d_irdy, d_ov, d_sat;
  logic [15:0] d_sum;
  logic [7:0]  d_cnt;

  ppc_accum u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ans(a_ans), .in_last(a_last),
    .in_ready(a_irdy), .out_valid(a_ov), .out_ready(a_ordy),
    .out_sum(a_sum), .out_count(a_cnt), .out_sat(a_sat));

  ppc_accum #(.ACC_W(16), .MAX_BEATS(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ans(b_ans), .in_last(b_last),
    .in_ready(b_irdy), .out_valid(b_ov), .out_ready(b_ordy),
    .out_sum(b_sum), .out_count(b_cnt), .out_sat(b_sat));

  ppc_accum #(.ACC_W(6), .MAX_BEATS(255)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ans(c_ans), .in_last(c_last),
    .in_ready(c_irdy), .out_valid(c_ov), .out_ready(c_ordy),
    .out_sum(c_sum), .out_count(c_cnt), .out_sat(c_sat));

  ppc_accum #(.ACC_W(16), .MAX_BEATS(1)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ans(d_ans), .in_last(d_last),
    .in_ready(d_irdy), .out_valid(d_ov), .out_ready(d_ordy),
    .out_sum(d_sum), .out_count(d_cnt), .out_sat(d_sat));

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_iv = 1'b1; a_ans = 4'd5; a_last = 1'b1;
    step();
    rst = 1'b0; a_iv = 1'b0; a_last = 1'b0;
    checks++;
    if (a_ov !== 1'b0 || a_sum !== 16'd0 || a_cnt !== 8'd0 || a_sat !== 1'b0 || a_irdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: ov=%b sum=%0d cnt=%0d sat=%b irdy=%b want 0/0/0/0/1",
               a_ov, a_sum, a_cnt, a_sat, a_irdy);
    end
    step();
    checks++;
    if (a_ov !== 1'b0 || a_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_discard: ov=%b cnt=%0d want ov=0 cnt=0", a_ov, a_cnt);
    end
  endtask

  task automatic test_basic();
    logic [3:0] beats [4] = '{4'd3, 4'd5, 4'd7, 4'd1};
    a_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_iv = 1'b1; a_ans = beats[i]; a_last = (i == 3);
      if (i > 0) begin
        checks++;
        if (a_ov !== 1'b0 || a_irdy !== 1'b1 || a_cnt !== 8'(i)) begin
          failures++;
          $display("FAIL basic_accum: ov=%b irdy=%b cnt=%0d want 0/1/%0d", a_ov, a_irdy, a_cnt, i);
        end
      end
      step();
    end
    a_iv = 1'b0; a_last = 1'b0;
    checks++;
    if (a_ov !== 1'b1 || a_sum !== 16'd16 || a_cnt !== 8'd4 || a_sat !== 1'b0 || a_irdy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: ov=%b sum=%0d cnt=%0d sat=%b irdy=%b want 1/16/4/0/0",
               a_ov, a_sum, a_cnt, a_sat, a_irdy);
    end
    step();
    checks++;
    if (a_ov !== 1'b0 || a_irdy !== 1'b1 || a_sum !== 16'd0 || a_cnt !== 8'd0) begin
      failures++;
      $display("FAIL basic_idle: ov=%b irdy=%b sum=%0d cnt=%0d want 0/1/0/0", a_ov, a_irdy, a_sum, a_cnt);
    end
    // Full 4-bit value must be zero-extended, not sign-extended.
    a_iv = 1'b1; a_ans = 4'd15; a_last = 1'b0; step();
    a_last = 1'b1; step();
    a_iv = 1'b0; a_last = 1'b0;
    checks++;
    if (a_ov !== 1'b1 || a_sum !== 16'd30 || a_cnt !== 8'd2 || a_sat !== 1'b0) begin
      failures++;
      $display("FAIL basic_zext: ov=%b sum=%0d cnt=%0d sat=%b want 1/30/2/0", a_ov, a_sum, a_cnt, a_sat);
    end
    step();
  endtask

  task automatic test_hold();
    a_ordy = 1'b0;
    a_iv = 1'b1; a_ans = 4'd1; a_last = 1'b0; step();
    a_ans = 4'd2; a_last = 1'b1; step();
    a_ans = 4'd9; a_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a_ov !== 1'b1 || a_irdy !== 1'b0 || a_sum !== 16'd3 || a_cnt !== 8'd2) begin
        failures++;
        $display("FAIL hold_stable[%0d]: ov=%b irdy=%b sum=%0d cnt=%0d want 1/0/3/2",
                 i, a_ov, a_irdy, a_sum, a_cnt);
      end
      step();
    end
    a_iv = 1'b0; a_last = 1'b0; a_ordy = 1'b1; step();
    a_iv = 1'b1; a_ans = 4'd4; a_last = 1'b1; step();
    a_iv = 1'b0; a_last = 1'b0;
    checks++;
    if (a_ov !== 1'b1 || a_sum !== 16'd4 || a_cnt !== 8'd1) begin
      failures++;
      $display("FAIL hold_next_burst: ov=%b sum=%0d cnt=%0d want 1/4/1", a_ov, a_sum, a_cnt);
    end
    step();
  endtask

  task automatic test_reset_midburst();
    a_ordy = 1'b1;
    a_iv = 1'b1; a_ans = 4'd4; a_last = 1'b0; step();
    a_ans = 4'd9; step();
    a_iv = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    checks++;
    if (a_ov !== 1'b0 || a_sum !== 16'd0 || a_cnt !== 8'd0 || a_irdy !== 1'b1) begin
      failures++;
      $display("FAIL rst_accum: ov=%b sum=%0d cnt=%0d irdy=%b want 0/0/0/1", a_ov, a_sum, a_cnt, a_irdy);
    end
    a_iv = 1'b1; a_ans = 4'd6; a_last = 1'b1; step();
    a_iv = 1'b0; a_last = 1'b0;
    checks++;
    if (a_ov !== 1'b1 || a_sum !== 16'd6 || a_cnt !== 8'd1) begin
      failures++;
      $display("FAIL rst_then_beat: ov=%b sum=%0d cnt=%0d want 1/6/1", a_ov, a_sum, a_cnt);
    end
    // Reset while the result is held drops it without a handoff.
    a_ordy = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    checks++;
    if (a_ov !== 1'b0 || a_sum !== 16'd0 || a_cnt !== 8'd0 || a_irdy !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold: ov=%b sum=%0d cnt=%0d irdy=%b want 0/0/0/1", a_ov, a_sum, a_cnt, a_irdy);
    end
    a_ordy = 1'b1;
  endtask

  task automatic test_back_to_back();
    a_ordy = 1'b1; a_iv = 1'b1; a_ans = 4'd0; a_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ((i % 2) == 0) begin
        if (a_ov !== 1'b1 || a_sum !== 16'd0 || a_cnt !== 8'd1 || a_irdy !== 1'b0) begin
          failures++;
          $display("FAIL b2b_hold[%0d]: ov=%b sum=%0d cnt=%0d irdy=%b want 1/0/1/0",
                   i, a_ov, a_sum, a_cnt, a_irdy);
        end
      end else begin
        if (a_ov !== 1'b0 || a_cnt !== 8'd0 || a_irdy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_bubble[%0d]: ov=%b cnt=%0d irdy=%b want 0/0/1", i, a_ov, a_cnt, a_irdy);
        end
      end
    end
    a_iv = 1'b0; a_last = 1'b0;
  endtask

  task automatic test_max_beats();
    b_ordy = 1'b1; b_iv = 1'b1; b_ans = 4'd2; b_last = 1'b0;
    step(); step(); step();
    checks++;
    if (b_ov !== 1'b0 || b_cnt !== 8'd3 || b_sum !== 16'd6) begin
      failures++;
      $display("FAIL maxb_open: ov=%b cnt=%0d sum=%0d want 0/3/6", b_ov, b_cnt, b_sum);
    end
    step();
    b_iv = 1'b0;
    checks++;
    if (b_ov !== 1'b1 || b_sum !== 16'd8 || b_cnt !== 8'd4 || b_sat !== 1'b0) begin
      failures++;
      $display("FAIL maxb_close: ov=%b sum=%0d cnt=%0d sat=%b want 1/8/4/0", b_ov, b_sum, b_cnt, b_sat);
    end
    step();
    // MAX_BEATS=1: a beat without in_last still closes the burst.
    d_ordy = 1'b1; d_iv = 1'b1; d_ans = 4'd11; d_last = 1'b0; step();
    d_iv = 1'b0;
    checks++;
    if (d_ov !== 1'b1 || d_sum !== 16'd11 || d_cnt !== 8'd1) begin
      failures++;
      $display("FAIL maxb_one: ov=%b sum=%0d cnt=%0d want 1/11/1", d_ov, d_sum, d_cnt);
    end
    step();
  endtask

  task automatic test_saturate();
    c_ordy = 1'b1; c_iv = 1'b1; c_ans = 4'd15;
    for (int i = 0; i < 5; i++) begin
      c_last = (i == 4);
      step();
    end
    c_iv = 1'b0; c_last = 1'b0;
    checks++;
    if (c_ov !== 1'b1 || c_sum !== 6'd63 || c_cnt !== 8'd5 || c_sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_clamp: ov=%b sum=%0d cnt=%0d sat=%b want 1/63/5/1", c_ov, c_sum, c_cnt, c_sat);
    end
    step();
    c_iv = 1'b1; c_ans = 4'd1; c_last = 1'b1; step();
    c_iv = 1'b0; c_last = 1'b0;
    checks++;
    if (c_ov !== 1'b1 || c_sum !== 6'd1 || c_cnt !== 8'd1 || c_sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_cleared: ov=%b sum=%0d cnt=%0d sat=%b want 1/1/1/0", c_ov, c_sum, c_cnt, c_sat);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_midburst();
    test_back_to_back();
    test_max_beats();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
